frame_ctl: RTL and testbench
============================

# frame_ctl

Frame-synchronous configuration scheduler for the VGA drawing pipeline. Requesters such as mouse logic and game FSM write new drawing configuration (background fill colour, layer/mode word) at any time. The block arbitrates between them round-robin and holds the latest accepted word in a shadow register. It commits that word to the active configuration only at the start of vertical blanking, so the `draw_*` stages never see a configuration change mid-frame.

## Interface

Parameters:
- `N_REQ`, 2: number of requesters (2..4).
- `CFG_W`, 12: configuration word width.
- `CFG_RESET`, 12'h8_8_8: active/shadow value after reset (gray fill).

Ports:
- `clk`  in  1  pixel clock, same as the VGA timing chain.
- `rst`  in  1  reset, asynchronous, active-low.
- `vblnk`  in  1  vertical blanking from the timing generator (vga_if vblnk).
- `req`  in  N_REQ  per-requester write request, level, held until ack.
- `cfg_in`  in  N_REQ*CFG_W  flattened request data; requester i occupies bits [i*CFG_W +: CFG_W]; stable while req[i]=1.
- `ack`  out  N_REQ  one-cycle accept pulse per requester.
- `cfg_active`  out  CFG_W  configuration used by the draw stages; changes only on a commit.
- `commit`  out  1  one-cycle pulse, cfg_active updated this cycle.
- `pending`  out  1  shadow holds an uncommitted write (state DIRTY).
- `frame_cnt`  out  16  count of vblnk rising edges.

## Operation

- Edge detect: vblnk_d is a registered copy of vblnk. `rise = vblnk & ~vblnk_d`.
- State machine has two states: CLEAN and DIRTY.
  - CLEAN -> DIRTY on any accepted write.
  - DIRTY -> CLEAN on rise, with commit performed.
  - On a rise in CLEAN: no commit, no pulse.
- Eligibility: requester i is eligible when req[i]=1 and ack[i]=0. The ack[i]=0 condition prevents double-accepting a request whose req is still high in its ack cycle.
- Arbitration: at most one grant per cycle, round-robin.
  - A last-grant pointer selects the search start at (last+1) mod N_REQ.
  - The pointer updates to the granted index.
  - Pointer resets to N_REQ-1, so requester 0 wins first.
- Accept: on a grant, the shadow loads the granted requester's cfg_in slice, ack[grant] is set for one cycle, and state becomes DIRTY.
- Multiple writes in one frame: last accepted write wins.
- Commit at rise with state DIRTY:
  - cfg_active <= shadow.
  - commit <= 1.
  - State becomes CLEAN.
- Simultaneous rise and eligible request: no grant in the rise cycle. The request is granted on a later cycle and lands in the next frame's commit. This keeps the committed value unambiguous.
- frame_cnt increments on every rise, independent of state, and wraps 16'hFFFF -> 0.
- The block does not touch hcount/vcount/rgb. Downstream stages sample cfg_active directly.

## Timing

- Reset values (asynchronous, while rst=0):
  - ack=0, commit=0, pending=0, frame_cnt=0.
  - cfg_active=CFG_RESET, shadow=CFG_RESET.
  - vblnk_d=0, state=CLEAN, pointer=N_REQ-1.
- Reset asserted mid-operation discards any pending shadow write: shadow returns to CFG_RESET and no commit occurs.
- First rising clk edge after release evaluates normally. If vblnk=1 at that edge, a rise is seen: frame_cnt becomes 1, and no commit occurs because state is CLEAN.
- Request-to-ack: req[i] sampled high at edge E (with no rise and i winning) gives ack[i]=1 during cycle E..E+1 and shadow updated at E.
- Sustained single requester holding req: accepted at most every other cycle.
- Commit latency: vblnk first sampled high at edge E produces cfg_active updated at E, and commit and frame_cnt update at E.
- Outputs are all registered; no combinational path from inputs to outputs.

## Test plan

- Reset: hold rst=0 with random inputs, then release -> cfg_active=12'h888, frame_cnt=0, ack=0, commit=0, pending=0. Assert rst=0 while DIRTY -> pending=0 immediately, with no commit at the next vblnk.
- Single write: req[0]=1, cfg_in slice0=12'hf00, then pulse vblnk -> ack[0] for exactly 1 cycle, pending=1, and cfg_active stays 12'h888 until the first vblnk-high edge. At that edge cfg_active=12'hf00, commit=1 for 1 cycle, pending=0, frame_cnt=1.
- Round-robin: req[0] and req[1] held continuously with 12'h0f0 / 12'h00f -> acks alternate 0,1,0,1. Shadow at the next commit equals the data of the last acked requester.
- Collision: assert req[1] in the same cycle vblnk rises -> no ack in the rise cycle, ack[1] one cycle later. The commit in this frame does not carry the req[1] data; the next frame's commit does.
- Last-writer wins: three writes 12'h111, 12'h222, 12'h333 in one frame -> a single commit with cfg_active=12'h333. A vblnk with no writes -> no commit, and frame_cnt still increments.
- Wrap: force 65536 vblnk pulses -> frame_cnt reads 0 after the last pulse, with no glitch on cfg_active.

Source files
------------

// File: rtl/frame_ctl.sv
// Frame-synchronous configuration scheduler: round-robin write arbitration into a
// shadow register, committed to the active configuration at the start of vblank.
module frame_ctl #(
    parameter int                N_REQ     = 2,
    parameter int                CFG_W     = 12,
    parameter logic [CFG_W-1:0]  CFG_RESET = 12'h888
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vblnk,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CFG_W-1:0]   cfg_in,
    output logic [N_REQ-1:0]         ack,
    output logic [CFG_W-1:0]         cfg_active,
    output logic                     commit,
    output logic                     pending,
    output logic [15:0]              frame_cnt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {CLEAN, DIRTY} state_t;

    state_t              state;
    logic                vblnk_d;
    logic [IW-1:0]       ptr;
    logic [CFG_W-1:0]    shadow;
    logic [15:0]         frame_q;
    logic [CFG_W-1:0]    cfg_arr [N_REQ];

    logic                rise;
    logic [N_REQ-1:0]    elig;
    logic                gnt_vld;
    logic [IW-1:0]       gnt_idx;
    logic [IW-1:0]       idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign cfg_arr[g] = cfg_in[g*CFG_W +: CFG_W];
    end

    assign rise      = vblnk & ~vblnk_d;
    // A request still high during its ack cycle must not be accepted twice.
    assign elig      = req & ~ack;
    assign pending   = (state == DIRTY);
    assign frame_cnt = frame_q;

    // Round-robin search starting just after the last grant; grants are
    // suppressed on a rise so the committed value is never ambiguous.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (rise) gnt_vld = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CLEAN;
            vblnk_d    <= 1'b0;
            ptr        <= IW'(N_REQ - 1);
            shadow     <= CFG_RESET;
            cfg_active <= CFG_RESET;
            frame_q    <= '0;
            ack        <= '0;
            commit     <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
            ack     <= '0;
            commit  <= 1'b0;
            if (rise) begin
                frame_q <= frame_q + 16'd1;
                if (state == DIRTY) begin
                    cfg_active <= shadow;
                    commit     <= 1'b1;
                    state      <= CLEAN;
                end
            end else if (gnt_vld) begin
                shadow       <= cfg_arr[gnt_idx];
                ack[gnt_idx] <= 1'b1;
                ptr          <= gnt_idx;
                state        <= DIRTY;
            end
        end
    end

endmodule

// File: tb/tb_frame_ctl.sv
// Bench for frame_ctl: directed scenarios plus randomized traffic, checked against
// a cycle-level reference model of the scheduler's rules.
module tb_frame_ctl;

    localparam int N = 2;
    localparam int W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             vblnk = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   cfg_in = '0;
    logic [N-1:0]     ack;
    logic [W-1:0]     cfg_active;
    logic             commit;
    logic             pending;
    logic [15:0]      frame_cnt;

    frame_ctl #(.N_REQ(N), .CFG_W(W), .CFG_RESET(12'h888)) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .req(req), .cfg_in(cfg_in),
        .ack(ack), .cfg_active(cfg_active), .commit(commit),
        .pending(pending), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // reference model state
    logic         m_vb_prev;
    logic [N-1:0] m_ack;
    logic         m_commit;
    logic         m_dirty;
    logic [W-1:0] m_shadow;
    logic [W-1:0] m_active;
    logic [15:0]  m_frame;
    int           m_last;

    int vecs = 0;
    int errs = 0;

    task automatic model_reset();
        m_vb_prev = 1'b0; m_ack = '0; m_commit = 1'b0; m_dirty = 1'b0;
        m_shadow = 12'h888; m_active = 12'h888; m_frame = 16'd0; m_last = N - 1;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] nack;
        bit           found;
        int           i;
        elig = req & ~m_ack;
        nack = '0;
        found = 1'b0;
        m_commit = 1'b0;
        if (vblnk && !m_vb_prev) begin
            m_frame = m_frame + 16'd1;
            if (m_dirty) begin
                m_active = m_shadow;
                m_commit = 1'b1;
                m_dirty  = 1'b0;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (!found && elig[i +: 1] == 1'b1) begin
                    found = 1'b1;
                    nack[i +: 1] = 1'b1;
                    m_shadow = cfg_in[i*W +: W];
                    m_dirty = 1'b1;
                    m_last = i;
                end
            end
        end
        m_ack = nack;
        m_vb_prev = vblnk;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ack"},        32'(ack),        32'(m_ack));
        check({tag, ".commit"},     32'(commit),     32'(m_commit));
        check({tag, ".pending"},    32'(pending),    32'(m_dirty));
        check({tag, ".cfg_active"}, 32'(cfg_active), 32'(m_active));
        check({tag, ".frame_cnt"},  32'(frame_cnt),  32'(m_frame));
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later,
    // then return to the falling edge where the next inputs are driven.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1 check_all(tag);
        @(negedge clk);
    endtask

    task automatic drop_acked();
        req = req & ~m_ack;
    endtask

    task automatic vblank_pulse(input string tag);
        vblnk = 1'b1; cycle(tag);
        vblnk = 1'b0; cycle(tag);
    endtask

    initial begin
        model_reset();
        // reset held with random inputs
        repeat (4) begin
            vblnk = 1'($urandom); req = N'($urandom);
            cfg_in = (N*W)'({$urandom, $urandom});
            @(negedge clk);
            check_all("reset_hold");
        end
        req = '0; vblnk = 1'b1;
        rst = 1'b1;
        // vblnk already high at the first edge: counts a frame, no commit
        cycle("first_edge");
        vblnk = 1'b0; cycle("first_edge_low");

        // single write then commit
        cfg_in[0 +: W] = 12'hf00; req[0] = 1'b1;
        cycle("single_wr");
        drop_acked();
        cycle("single_ack_end");
        cycle("single_wait");
        vblank_pulse("single_commit");

        // round robin with both requesters held
        cfg_in[0 +: W] = 12'h0f0; cfg_in[W +: W] = 12'h00f; req = 2'b11;
        repeat (6) cycle("rr");
        req = '0; cycle("rr_idle");
        vblank_pulse("rr_commit");

        // collision: request raised in the rise cycle
        vblnk = 1'b1; cfg_in[W +: W] = 12'habc; req[1] = 1'b1;
        cycle("coll_rise");
        vblnk = 1'b0;
        cycle("coll_ack");
        drop_acked(); cycle("coll_idle");
        vblank_pulse("coll_next");

        // last writer wins within one frame
        cfg_in[0 +: W] = 12'h111; req[0] = 1'b1; cycle("lw1"); drop_acked(); cycle("lw1b");
        cfg_in[W +: W] = 12'h222; req[1] = 1'b1; cycle("lw2"); drop_acked(); cycle("lw2b");
        cfg_in[0 +: W] = 12'h333; req[0] = 1'b1; cycle("lw3"); drop_acked(); cycle("lw3b");
        vblank_pulse("lw_commit");
        vblank_pulse("no_write_frame");

        // reset while dirty discards the shadow write
        cfg_in[W +: W] = 12'h5a5; req[1] = 1'b1; cycle("rst_dirty_wr"); drop_acked();
        cycle("rst_dirty_hold");
        #2 rst = 1'b0; model_reset();
        #1 check_all("rst_async");
        @(negedge clk); rst = 1'b1;
        cycle("rst_release");
        vblank_pulse("rst_no_commit");

        // frame counter wrap, preloaded near the top
        force dut.frame_q = 16'hfffd;
        #1 release dut.frame_q;
        m_frame = 16'hfffd;
        repeat (3) vblank_pulse("wrap");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] == 1'b0 && ($urandom % 3) == 0) begin
                    cfg_in[i*W +: W] = W'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (($urandom % 8) == 0) vblnk = ~vblnk;
            cycle("rand");
            drop_acked();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
